// File: rtl/pebble_pkg.sv
// Shared core constants and register-file types used by writeback, regfile and decoder.
package pebble_pkg;

    localparam int unsigned DW   = 8;
    localparam int unsigned NREG = 4;
    localparam int unsigned AW   = $clog2(NREG);

    typedef logic [AW-1:0] reg_addr_t;
    typedef logic [DW-1:0] word_t;

    // One register-file write: destination plus value.
    typedef struct packed {
        reg_addr_t addr;
        word_t     data;
    } wb_payload_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Tracks registers with an outstanding load and flags load/ALU protocol violations.
module wb_scoreboard
    import pebble_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            issue,
    input  reg_addr_t       issue_dest,
    input  logic            ret,
    input  reg_addr_t       ret_dest,
    input  logic            alu_accept,
    input  reg_addr_t       alu_dest,
    output logic [NREG-1:0] pending,
    output logic            err_pulse_c
);

    logic [NREG-1:0] pending_nxt_c;

    // Issue is applied after return so a same-register pair leaves the bit set.
    always_comb begin
        pending_nxt_c = pending;
        if (ret) begin
            pending_nxt_c[ret_dest] = 1'b0;
        end
        if (issue) begin
            pending_nxt_c[issue_dest] = 1'b1;
        end
    end

    always_comb begin
        err_pulse_c = 1'b0;
        if (issue && pending[issue_dest] && !(ret && (ret_dest == issue_dest))) begin
            err_pulse_c = 1'b1;
        end
        if (ret && !pending[ret_dest]) begin
            err_pulse_c = 1'b1;
        end
        if (alu_accept && pending[alu_dest]) begin
            err_pulse_c = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt_c;
        end
    end

endmodule

// File: rtl/writeback_unit.sv
// Final pipeline stage: arbitrates load returns and ALU results onto the single
// register-file write port and reports per-register hazards to the decoder.
module writeback_unit
    import pebble_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_dest,
    input  logic [DW-1:0]   alu_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_dest,
    input  logic            ld_valid,
    input  logic [AW-1:0]   ld_dest,
    input  logic [DW-1:0]   ld_data,
    output logic            write_enable,
    output logic [AW-1:0]   write_addr,
    output logic [DW-1:0]   write_data,
    output logic [NREG-1:0] reg_busy,
    output logic            err
);

    logic            hold_valid;
    wb_payload_t     hold;
    logic            alu_accept_c;
    logic [NREG-1:0] pending;
    logic            err_pulse_c;

    // Ready depends only on the hold buffer, so a held result is never overtaken.
    assign alu_ready    = !hold_valid;
    assign alu_accept_c = alu_valid && !hold_valid;

    wb_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue       (ld_issue),
        .issue_dest  (ld_issue_dest),
        .ret         (ld_valid),
        .ret_dest    (ld_dest),
        .alu_accept  (alu_accept_c),
        .alu_dest    (alu_dest),
        .pending     (pending),
        .err_pulse_c (err_pulse_c)
    );

    // Write-out priority: load return, then held ALU result, then bypassed ALU result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
            hold_valid   <= 1'b0;
            hold         <= '0;
            err          <= 1'b0;
        end else begin
            if (ld_valid) begin
                write_enable <= 1'b1;
                write_addr   <= ld_dest;
                write_data   <= ld_data;
                if (alu_accept_c) begin
                    hold_valid <= 1'b1;
                    hold       <= wb_payload_t'{addr: alu_dest, data: alu_data};
                end
            end else if (hold_valid) begin
                write_enable <= 1'b1;
                write_addr   <= hold.addr;
                write_data   <= hold.data;
                hold_valid   <= 1'b0;
            end else if (alu_accept_c) begin
                write_enable <= 1'b1;
                write_addr   <= alu_dest;
                write_data   <= alu_data;
            end else begin
                write_enable <= 1'b0;
            end
            if (err_pulse_c) begin
                err <= 1'b1;
            end
        end
    end

    // Hazard view built from registered state only.
    always_comb begin
        reg_busy = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            reg_busy[r] = pending[r]
                        | (hold_valid && (hold.addr == AW'(r)))
                        | (write_enable && (write_addr == AW'(r)));
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed vector table plus randomized run against a queue-based reference model.
module tb_writeback_unit;
    import pebble_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            alu_valid;
    logic            alu_ready;
    logic [AW-1:0]   alu_dest;
    logic [DW-1:0]   alu_data;
    logic            ld_issue;
    logic [AW-1:0]   ld_issue_dest;
    logic            ld_valid;
    logic [AW-1:0]   ld_dest;
    logic [DW-1:0]   ld_data;
    logic            write_enable;
    logic [AW-1:0]   write_addr;
    logic [DW-1:0]   write_data;
    logic [NREG-1:0] reg_busy;
    logic            err;

    int errors = 0;
    int checks = 0;

    writeback_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_dest      (alu_dest),
        .alu_data      (alu_data),
        .ld_issue      (ld_issue),
        .ld_issue_dest (ld_issue_dest),
        .ld_valid      (ld_valid),
        .ld_dest       (ld_dest),
        .ld_data       (ld_data),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .write_data    (write_data),
        .reg_busy      (reg_busy),
        .err           (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       av;
        logic [1:0] ad;
        logic [7:0] adata;
        logic       li;
        logic [1:0] lid;
        logic       lv;
        logic [1:0] ld;
        logic [7:0] ldata;
        logic       e_we;
        logic [1:0] e_addr;
        logic [7:0] e_data;
        logic       e_rdy;
        logic [3:0] e_busy;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic av, logic [1:0] ad, logic [7:0] adata,
                                logic li, logic [1:0] lid, logic lv, logic [1:0] ld,
                                logic [7:0] ldata, logic we, logic [1:0] wa, logic [7:0] wd,
                                logic rdy, logic [3:0] busy, logic e);
        vec_t v;
        v.rst_n = r;  v.av = av; v.ad = ad; v.adata = adata;
        v.li = li;    v.lid = lid; v.lv = lv; v.ld = ld; v.ldata = ldata;
        v.e_we = we;  v.e_addr = wa; v.e_data = wd; v.e_rdy = rdy;
        v.e_busy = busy; v.e_err = e;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic av, input logic [1:0] ad, input logic [7:0] adata,
                         input logic li, input logic [1:0] lid, input logic lv, input logic [1:0] ld,
                         input logic [7:0] ldata);
        rst_n = r; alu_valid = av; alu_dest = ad; alu_data = adata;
        ld_issue = li; ld_issue_dest = lid; ld_valid = lv; ld_dest = ld; ld_data = ldata;
    endtask

    // Reference model: spec rules with a queue standing in for the hold buffer.
    typedef struct { logic [1:0] addr; logic [7:0] data; } wr_t;
    wr_t        m_hold[$];
    logic       m_we;
    logic [1:0] m_addr;
    logic [7:0] m_data;
    logic [3:0] m_pend;
    logic       m_err;

    task automatic model_step();
        bit acc;
        wr_t w;
        if (!rst_n) begin
            m_hold.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_pend = 0; m_err = 0;
            return;
        end
        acc = alu_valid && (m_hold.size() == 0);
        if (ld_issue && m_pend[ld_issue_dest] && !(ld_valid && ld_dest == ld_issue_dest)) m_err = 1;
        if (ld_valid && !m_pend[ld_dest]) m_err = 1;
        if (acc && m_pend[alu_dest]) m_err = 1;
        if (ld_valid) m_pend[ld_dest] = 0;
        if (ld_issue) m_pend[ld_issue_dest] = 1;
        if (ld_valid) begin
            m_we = 1; m_addr = ld_dest; m_data = ld_data;
            if (acc) begin
                w.addr = alu_dest; w.data = alu_data;
                m_hold.push_back(w);
            end
        end else if (m_hold.size() != 0) begin
            w = m_hold.pop_front();
            m_we = 1; m_addr = w.addr; m_data = w.data;
        end else if (acc) begin
            m_we = 1; m_addr = alu_dest; m_data = alu_data;
        end else begin
            m_we = 0;
        end
    endtask

    function automatic logic [3:0] model_busy();
        logic [3:0] b;
        b = m_pend;
        foreach (m_hold[i]) b[m_hold[i].addr] = 1'b1;
        if (m_we) b[m_addr] = 1'b1;
        return b;
    endfunction

    initial begin
        // rst, alu v/d/data, issue v/d, ld v/d/data | we, addr, data, rdy, busy, err
        tbl.push_back(mk(0, 0,0,8'h00, 0,0, 0,0,8'h00, 0,0,8'h00, 1,4'b0000, 0));
        tbl.push_back(mk(1, 1,2,8'h5A, 0,0, 0,0,8'h00, 1,2,8'h5A, 1,4'b0100, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,2,8'h5A, 1,4'b0000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,1, 0,0,8'h00, 0,2,8'h5A, 1,4'b0010, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,2,8'h5A, 1,4'b0010, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 1,1,8'hC3, 1,1,8'hC3, 1,4'b0010, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,1,8'hC3, 1,4'b0000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,0, 0,0,8'h00, 0,1,8'hC3, 1,4'b0001, 0));
        tbl.push_back(mk(1, 1,3,8'h22, 0,0, 1,0,8'h11, 1,0,8'h11, 0,4'b1001, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 1,3,8'h22, 1,4'b1000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,3,8'h22, 1,4'b0000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,0, 0,0,8'h00, 0,3,8'h22, 1,4'b0001, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,1, 0,0,8'h00, 0,3,8'h22, 1,4'b0011, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,2, 0,0,8'h00, 0,3,8'h22, 1,4'b0111, 0));
        tbl.push_back(mk(1, 1,3,8'h33, 1,0, 1,0,8'hA0, 1,0,8'hA0, 0,4'b1111, 0));
        tbl.push_back(mk(1, 1,0,8'h44, 0,0, 1,1,8'hA1, 1,1,8'hA1, 0,4'b1111, 0));
        tbl.push_back(mk(1, 1,0,8'h44, 0,0, 1,2,8'hA2, 1,2,8'hA2, 0,4'b1101, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 1,0,8'hA3, 1,0,8'hA3, 0,4'b1001, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 1,3,8'h33, 1,4'b1000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,3,8'h33, 1,4'b0000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,2, 0,0,8'h00, 0,3,8'h33, 1,4'b0100, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 1,2, 1,2,8'hB1, 1,2,8'hB1, 1,4'b0100, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 1,2,8'hB2, 1,2,8'hB2, 1,4'b0100, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 1,2,8'hB3, 1,2,8'hB3, 1,4'b0100, 1));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,2,8'hB3, 1,4'b0000, 1));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,2,8'hB3, 1,4'b0000, 1));
        tbl.push_back(mk(1, 0,0,8'h00, 1,1, 0,0,8'h00, 0,2,8'hB3, 1,4'b0010, 1));
        tbl.push_back(mk(1, 0,0,8'h00, 1,0, 0,0,8'h00, 0,2,8'hB3, 1,4'b0011, 1));
        tbl.push_back(mk(1, 1,3,8'h66, 0,0, 1,0,8'h55, 1,0,8'h55, 0,4'b1011, 1));
        tbl.push_back(mk(0, 1,2,8'h77, 0,0, 0,0,8'h00, 0,0,8'h00, 1,4'b0000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,0,8'h00, 1,4'b0000, 0));
        tbl.push_back(mk(1, 0,0,8'h00, 0,0, 0,0,8'h00, 0,0,8'h00, 1,4'b0000, 0));

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            drive(tbl[i].rst_n, tbl[i].av, tbl[i].ad, tbl[i].adata,
                  tbl[i].li, tbl[i].lid, tbl[i].lv, tbl[i].ld, tbl[i].ldata);
            @(posedge clk); #1;
            chk("dir_we",   i, 32'(write_enable), 32'(tbl[i].e_we));
            chk("dir_addr", i, 32'(write_addr),   32'(tbl[i].e_addr));
            chk("dir_data", i, 32'(write_data),   32'(tbl[i].e_data));
            chk("dir_rdy",  i, 32'(alu_ready),    32'(tbl[i].e_rdy));
            chk("dir_busy", i, 32'(reg_busy),     32'(tbl[i].e_busy));
            chk("dir_err",  i, 32'(err),          32'(tbl[i].e_err));
        end

        // Randomized phase, biased toward legal load traffic with occasional violations.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        model_step();
        #1;
        for (int n = 0; n < 3000; n++) begin
            logic       r, av, li, lv;
            logic [1:0] ad, lid, ldst;
            r   = ($urandom_range(0, 149) != 0);
            av  = ($urandom_range(0, 1) == 1);
            ad  = 2'($urandom_range(0, 3));
            li  = ($urandom_range(0, 3) == 0);
            lid = 2'($urandom_range(0, 3));
            ldst = 2'($urandom_range(0, 3));
            lv  = 1'b0;
            if (m_pend != 4'b0000 && $urandom_range(0, 2) != 0) begin
                while (!m_pend[ldst]) ldst = ldst + 2'd1;
                lv = 1'b1;
            end else if ($urandom_range(0, 40) == 0) begin
                lv = 1'b1;
            end
            if (li && m_pend[lid] && $urandom_range(0, 9) != 0) li = 1'b0;
            if (av && m_pend[ad] && $urandom_range(0, 9) != 0) av = 1'b0;
            drive(r, av, ad, 8'($urandom), li, lid, lv, ldst, 8'($urandom));
            @(posedge clk);
            model_step();
            #1;
            chk("rnd_we",   n, 32'(write_enable), 32'(m_we));
            chk("rnd_addr", n, 32'(write_addr),   32'(m_addr));
            chk("rnd_data", n, 32'(write_data),   32'(m_data));
            chk("rnd_rdy",  n, 32'(alu_ready),    32'(m_hold.size() == 0));
            chk("rnd_busy", n, 32'(reg_busy),     32'(model_busy()));
            chk("rnd_err",  n, 32'(err),          32'(m_err));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
